// File: rtl/noc_credit_link.sv
// Pipelined point-to-point NoC link: flits forward, credits backward, NUM_PIPELINE stages each way.
// Define NOC_LINK_MONITOR_EN to build the credit/framing monitor and traffic counters.
module noc_credit_link #(
  parameter int unsigned FLIT_WIDTH   = 64,
  parameter int unsigned DEST_WIDTH   = 6,
  parameter int unsigned NUM_PIPELINE = 1,
  parameter int unsigned CREDITS      = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLIT_WIDTH-1:0]            data_in,
  input  logic [DEST_WIDTH-1:0]            dest_in,
  input  logic                             is_tail_in,
  input  logic                             send_in,
  output logic                             credit_out,
  output logic [FLIT_WIDTH-1:0]            data_out,
  output logic [DEST_WIDTH-1:0]            dest_out,
  output logic                             is_tail_out,
  output logic                             send_out,
  input  logic                             credit_in,
  output logic [$clog2(CREDITS+1)-1:0]     credits_avail,
  output logic                             err_overflow,
  output logic                             err_underflow,
  output logic                             err_framing,
  output logic [CNT_WIDTH-1:0]             flit_count,
  output logic [CNT_WIDTH-1:0]             pkt_count
);

  localparam int unsigned CW = $clog2(CREDITS + 1);

  generate
    if (NUM_PIPELINE == 0) begin : g_bypass
      assign data_out    = data_in;
      assign dest_out    = dest_in;
      assign is_tail_out = is_tail_in;
      assign send_out    = send_in;
      assign credit_out  = credit_in;
    end else begin : g_pipe
      logic [FLIT_WIDTH-1:0]   r_data [NUM_PIPELINE];
      logic [DEST_WIDTH-1:0]   r_dest [NUM_PIPELINE];
      logic [NUM_PIPELINE-1:0] r_tail;
      logic [NUM_PIPELINE-1:0] r_send;
      logic [NUM_PIPELINE-1:0] r_credit;

      // Payload registers hold their value on idle cycles; only send/tail/credit shift every cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_send   <= '0;
          r_tail   <= '0;
          r_credit <= '0;
          for (int unsigned k = 0; k < NUM_PIPELINE; k++) begin
            r_data[k] <= '0;
            r_dest[k] <= '0;
          end
        end else begin
          r_send[0]   <= send_in;
          r_tail[0]   <= is_tail_in;
          r_credit[0] <= credit_in;
          if (send_in) begin
            r_data[0] <= data_in;
            r_dest[0] <= dest_in;
          end
          for (int unsigned k = 1; k < NUM_PIPELINE; k++) begin
            r_send[k]   <= r_send[k-1];
            r_tail[k]   <= r_tail[k-1];
            r_credit[k] <= r_credit[k-1];
            if (r_send[k-1]) begin
              r_data[k] <= r_data[k-1];
              r_dest[k] <= r_dest[k-1];
            end
          end
        end
      end

      assign data_out    = r_data[NUM_PIPELINE-1];
      assign dest_out    = r_dest[NUM_PIPELINE-1];
      assign is_tail_out = r_tail[NUM_PIPELINE-1];
      assign send_out    = r_send[NUM_PIPELINE-1];
      assign credit_out  = r_credit[NUM_PIPELINE-1];
    end
  endgenerate

`ifdef NOC_LINK_MONITOR_EN
  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } frame_state_t;

  frame_state_t          r_state;
  frame_state_t          w_state_next;
  logic                  w_latch_dest;
  logic                  w_framing_err;
  logic [DEST_WIDTH-1:0] r_pkt_dest;
  logic [CW-1:0]         r_credits;
  logic                  r_err_ovf;
  logic                  r_err_unf;
  logic                  r_err_frm;
  logic [CNT_WIDTH-1:0]  r_flit_cnt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  // A send and a returned credit in the same cycle cancel, even at the balance limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CW'(CREDITS);
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      case ({send_in, credit_out})
        2'b10: begin
          if (r_credits == '0) r_err_ovf <= 1'b1;
          else                 r_credits <= r_credits - CW'(1);
        end
        2'b01: begin
          if (r_credits == CW'(CREDITS)) r_err_unf <= 1'b1;
          else                           r_credits <= r_credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_latch_dest  = 1'b0;
    w_framing_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (send_in && !is_tail_in) begin
          w_state_next = ST_BODY;
          w_latch_dest = 1'b1;
        end
      end
      ST_BODY: begin
        if (send_in) begin
          if (dest_in != r_pkt_dest) w_framing_err = 1'b1;
          if (is_tail_in)            w_state_next  = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pkt_dest <= '0;
      r_err_frm  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch_dest)  r_pkt_dest <= dest_in;
      if (w_framing_err) r_err_frm  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (send_out) begin
      r_flit_cnt <= r_flit_cnt + CNT_WIDTH'(1);
      if (is_tail_out) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
    end
  end

  assign credits_avail = r_credits;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
  assign err_framing   = r_err_frm;
  assign flit_count    = r_flit_cnt;
  assign pkt_count     = r_pkt_cnt;
`else
  assign credits_avail = CW'(CREDITS);
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
  assign err_framing   = 1'b0;
  assign flit_count    = '0;
  assign pkt_count     = '0;
`endif

endmodule
